// File: rtl/rv_regfile_pkg.sv
// Shared types and constants for the integer register file with busy scoreboard.
package rv_regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ZERO     = 0;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 mask, same-cycle write bypass and busy masking.
module regfile_read_port
    import rv_regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int AW   = 5
) (
    input  logic            run,
    input  logic [AW-1:0]   rd_addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic [XLEN-1:0] arr_data,
    input  logic            busy_bit,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_busy
);

    logic wr_hit;
    logic iss_hit;

    always_comb begin
        wr_hit  = wr_en && (wr_addr == rd_addr);
        iss_hit = iss_en && (iss_addr == rd_addr);
        rd_data = '0;
        rd_busy = 1'b0;
        if (run) begin
            if (rd_addr == AW'(REG_ZERO)) begin
                rd_data = '0;
            end else if (wr_hit) begin
                rd_data = wr_data;
            end else begin
                rd_data = arr_data;
            end
            // A writeback clears the hazard this cycle unless a new producer claims the register.
            rd_busy = busy_bit & ~(wr_hit & ~iss_hit);
        end
    end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with write bypass, busy scoreboard and
// a post-reset clear sequencer that zeroes the array one entry per cycle.
module regfile_mp_scoreboard
    import rv_regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int NRD   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    output logic              ready
);

    rf_state_t          state_q, state_d;
    logic [AW-1:0]      clr_idx_q, clr_idx_d;
    logic [NREGS-1:0]   busy_q, busy_d;
    logic [XLEN-1:0]    rf_q [NREGS];

    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [XLEN-1:0]    rf_wdata;
    logic               run;

    assign run   = (state_q == RF_RUN);
    assign ready = run;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
        rf_we     = 1'b0;
        rf_waddr  = wr_addr;
        rf_wdata  = wr_data;
        if (state_q == RF_CLEAR) begin
            // Sweep the array with zeros; all external requests are ignored meanwhile.
            rf_we     = 1'b1;
            rf_waddr  = clr_idx_q;
            rf_wdata  = '0;
            clr_idx_d = clr_idx_q + AW'(1);
            if (clr_idx_q == AW'(NREGS - 1)) begin
                state_d = RF_RUN;
            end
        end else begin
            rf_we = wr_en && (wr_addr != AW'(REG_ZERO));
            if (flush) begin
                busy_d = '0;
            end else begin
                if (wr_en) begin
                    busy_d[wr_addr] = 1'b0;
                end
                if (iss_en && (iss_addr != AW'(REG_ZERO))) begin
                    busy_d[iss_addr] = 1'b1;
                end
            end
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    // No reset on the storage so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr[p*AW +: AW];

        regfile_read_port #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_port (
            .run      (run),
            .rd_addr  (addr),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .iss_en   (iss_en),
            .iss_addr (iss_addr),
            .arr_data (rf_q[addr]),
            .busy_bit (busy_q[addr]),
            .rd_data  (rd_data[p*XLEN +: XLEN]),
            .rd_busy  (rd_busy[p])
        );
    end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Randomized scoreboard bench for regfile_mp_scoreboard (3 read ports) with a behavioural model.
module tb_regfile_mp_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [XLEN-1:0]      wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic                 flush;
    logic                 ready;

    always #5 clk = ~clk;

    regfile_mp_scoreboard #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .ready    (ready)
    );

    typedef struct packed {
        logic                rdy;
        logic [NRD*XLEN-1:0] d;
        logic [NRD-1:0]      b;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    // Reference model: architectural state plus remaining clear cycles.
    bit              known = 0;
    bit              m_run = 0;
    int              m_clr_left = 0;
    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_busy [NREGS];

    task automatic drive(input bit r, input bit we, input int wa, input logic [XLEN-1:0] wd,
                         input bit ie, input int ia, input bit fl,
                         input int a0, input int a1, input int a2);
        int   ap[NRD];
        exp_t e;
        ap[0] = a0; ap[1] = a1; ap[2] = a2;
        rst = r; wr_en = we; wr_addr = AW'(wa); wr_data = wd;
        iss_en = ie; iss_addr = AW'(ia); flush = fl;
        for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'(ap[p]);
        if (known) begin
            e = '0;
            e.rdy = m_run;
            if (m_run) begin
                for (int p = 0; p < NRD; p++) begin
                    if (ap[p] == 0)                   e.d[p*XLEN +: XLEN] = '0;
                    else if (we && wa == ap[p])       e.d[p*XLEN +: XLEN] = wd;
                    else                              e.d[p*XLEN +: XLEN] = m_mem[ap[p]];
                    e.b[p] = m_busy[ap[p]] && !(we && wa == ap[p] && !(ie && ia == ap[p]));
                end
            end
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            known = 1; m_run = 0; m_clr_left = NREGS;
            for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
        end else if (known && !m_run) begin
            m_clr_left--;
            if (m_clr_left == 0) begin
                m_run = 1;
                for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
            end
        end else if (known) begin
            if (we && wa != 0) m_mem[wa] = wd;
            if (fl) begin
                for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
            end else begin
                if (we) m_busy[wa] = 0;
                if (ie && ia != 0) m_busy[ia] = 1;
            end
        end
    endtask

    task automatic idle(input int a0, input int a1, input int a2);
        drive(0, 0, 0, '0, 0, 0, 0, a0, a1, a2);
    endtask

    function automatic int raddr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS - 1))
                                           : int'($urandom_range(0, 7));
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            nvec++;
            if (ready !== e.rdy) begin
                nerr++;
                $display("FAIL ready: got %b expected %b at %0t", ready, e.rdy, $time);
            end
            for (int p = 0; p < NRD; p++) begin
                nvec++;
                if (rd_data[p*XLEN +: XLEN] !== e.d[p*XLEN +: XLEN]) begin
                    nerr++;
                    $display("FAIL rd_data[%0d] addr %0d: got %h expected %h at %0t", p,
                             rd_addr[p*AW +: AW], rd_data[p*XLEN +: XLEN], e.d[p*XLEN +: XLEN], $time);
                end
                nvec++;
                if (rd_busy[p] !== e.b[p]) begin
                    nerr++;
                    $display("FAIL rd_busy[%0d] addr %0d: got %b expected %b at %0t", p,
                             rd_addr[p*AW +: AW], rd_busy[p], e.b[p], $time);
                end
            end
        end
    end

    initial begin
        int n;
        rst = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
        iss_en = 0; iss_addr = '0; flush = 0; rd_addr = '0;

        // Reset, then requests during CLEAR that must be ignored
        drive(1, 0, 0, '0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NREGS; i++)
            drive(0, 1, i, $urandom, 1, i, i % 5 == 0, i, raddr(), raddr());
        for (int i = 0; i < NREGS; i++) idle(i, (i + 1) % NREGS, (i + 2) % NREGS);

        // Restart in the middle of CLEAR
        drive(1, 0, 0, '0, 0, 0, 0, 1, 2, 3);
        for (int i = 0; i < 10; i++) idle(raddr(), raddr(), raddr());
        drive(1, 0, 0, '0, 0, 0, 0, 1, 2, 3);
        for (int i = 0; i < NREGS + 3; i++) idle(raddr(), raddr(), raddr());

        // Write with bypass, then from the array; x0 write dropped
        drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5, 0);
        idle(5, 0, 5);
        drive(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0);
        idle(0, 5, 0);

        // Scoreboard set and same-cycle clear
        drive(0, 0, 0, '0, 1, 7, 0, 7, 7, 0);
        idle(7, 0, 7);
        drive(0, 1, 7, 32'h77, 0, 0, 0, 7, 7, 7);
        idle(7, 7, 0);

        // Issue and write together, then flush with issue
        drive(0, 1, 9, 32'h55, 1, 9, 0, 9, 9, 0);
        idle(9, 9, 9);
        drive(0, 0, 0, '0, 1, 3, 0, 3, 9, 0);
        drive(0, 0, 0, '0, 1, 3, 1, 3, 9, 0);
        idle(3, 9, 0);

        // Three ports during a bypassing write to x1
        drive(0, 1, 1, 32'hA5, 0, 0, 0, 1, 1, 0);
        idle(1, 1, 0);

        // Randomized traffic with occasional restarts
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 399) == 0, $urandom_range(0, 1) == 1, raddr(), $urandom,
                  $urandom_range(0, 9) < 4, raddr(), $urandom_range(0, 15) == 0,
                  raddr(), raddr(), raddr());
        end

        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            nerr++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
